dmem_bus_lsu: RTL and testbench

DMEM_BUS_LSU -- requirements
Module: dmem_bus_lsu

---
 rtl/dmem_bus_lsu.sv | 173 +++++++++++++++++
 tb/tb_dmem_bus_lsu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_lsu.sv
// dmem_bus_lsu -- load/store unit bridging a RISC-V core data port onto a
// simple request/acknowledge data bus with a shared bidirectional data lane.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req, we       core access request (sampled in IDLE), 1 = store
//   funct3        RISC-V load/store access type
//   addr, wdata   byte address, right-aligned store data
//   busy, done    access in flight, 1-cycle completion pulse
//   rdata         sign/zero-extended load result, held between loads
//   err_req       1-cycle pulse on misaligned or illegal request
//   err_timeout   1-cycle pulse when the bus never acknowledges
//   DAD, MREQ     bus address and request
//   WRITE, SIZE   bus direction (1 = write), size (00 word, 01 half, 10 byte)
//   DDT           bidirectional data bus, driven only during writes
//   ACKD_n        bus acknowledge, active-low
//
// TIMEOUT: number of unacknowledged bus cycles tolerated before abort.
module dmem_bus_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err_req,
  output logic        err_timeout,
  output logic [31:0] DAD,
  output logic        MREQ,
  output logic        WRITE,
  output logic [1:0]  SIZE,
  inout  wire  [31:0] DDT,
  input  logic        ACKD_n
);

  typedef enum logic {
    IDLE,
    BUS
  } state_t;

  state_t      state;
  logic [7:0]  tcnt;
  logic [2:0]  f3_q;
  logic [31:0] ddt_q;

  logic        legal;
  logic [1:0]  size_enc;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic [8:0]  cnt_inc;
  logic        tmo_hit;

  // Request legality: alignment by access width, unsigned loads only for loads.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr[0];
      3'b010:  legal = (addr[1:0] == 2'b00);
      3'b100:  legal = ~we;
      3'b101:  legal = ~we & ~addr[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    size_enc   = 2'b00;
    store_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        size_enc   = 2'b10;
        store_data = {24'b0, wdata[7:0]};
      end
      2'b01: begin
        size_enc   = 2'b01;
        store_data = {16'b0, wdata[15:0]};
      end
      default: begin
        size_enc   = 2'b00;
        store_data = wdata;
      end
    endcase
  end

  always_comb begin
    load_data = DDT;
    case (f3_q)
      3'b000:  load_data = {{24{DDT[7]}}, DDT[7:0]};
      3'b001:  load_data = {{16{DDT[15]}}, DDT[15:0]};
      3'b100:  load_data = {24'b0, DDT[7:0]};
      3'b101:  load_data = {16'b0, DDT[15:0]};
      default: load_data = DDT;
    endcase
  end

  // Abort on the edge where this unacknowledged cycle would bring the
  // count to TIMEOUT, so MREQ stays high for exactly TIMEOUT cycles.
  always_comb begin
    cnt_inc = {1'b0, tcnt} + 9'd1;
    tmo_hit = ({23'b0, cnt_inc} >= TIMEOUT);
  end

  // Reset clears MREQ asynchronously, which also releases DDT at once.
  assign DDT = (MREQ && WRITE) ? ddt_q : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      f3_q        <= '0;
      ddt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata       <= '0;
      err_req     <= 1'b0;
      err_timeout <= 1'b0;
      DAD         <= '0;
      MREQ        <= 1'b0;
      WRITE       <= 1'b0;
      SIZE        <= 2'b00;
    end else begin
      done        <= 1'b0;
      err_req     <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (legal) begin
              DAD   <= addr;
              WRITE <= we;
              SIZE  <= size_enc;
              f3_q  <= funct3;
              ddt_q <= store_data;
              tcnt  <= '0;
              MREQ  <= 1'b1;
              busy  <= 1'b1;
              state <= BUS;
            end else begin
              err_req <= 1'b1;
            end
          end
        end
        BUS: begin
          if (!ACKD_n) begin
            if (!WRITE) rdata <= load_data;
            MREQ  <= 1'b0;
            WRITE <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (tmo_hit) begin
            tcnt        <= cnt_inc[7:0];
            MREQ        <= 1'b0;
            WRITE       <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            tcnt <= cnt_inc[7:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_lsu.sv
// Directed bench for dmem_bus_lsu (TIMEOUT overridden to 4).
module tb_dmem_bus_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err_req, err_timeout, MREQ, WRITE;
  logic [31:0] rdata, DAD;
  logic [1:0]  SIZE;
  logic        ACKD_n = 1'b1;
  wire  [31:0] DDT;

  logic        bus_en = 1'b0;
  logic [31:0] bus_drv = '0;
  assign DDT = bus_en ? bus_drv : 'z;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] PROBE = 32'hA5A5A5A5;

  dmem_bus_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .err_req(err_req), .err_timeout(err_timeout), .DAD(DAD), .MREQ(MREQ),
    .WRITE(WRITE), .SIZE(SIZE), .DDT(DDT), .ACKD_n(ACKD_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a known value and confirm the DUT is not fighting it.
  task automatic probe_released(input string tag);
    bus_drv = PROBE;
    bus_en  = 1'b1;
    #1;
    chk(tag, DDT, PROBE);
    bus_en  = 1'b0;
  endtask

  task automatic request(input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_mreq", {31'b0, MREQ}, 32'd0);
    chk("rst_write", {31'b0, WRITE}, 32'd0);
    chk("rst_size", {30'b0, SIZE}, 32'd0);
    chk("rst_dad", DAD, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_errs", {30'b0, err_req, err_timeout}, 32'd0);
    probe_released("rst_ddt_z");
    rst = 1'b0;
    tick();

    // Acknowledge while idle is ignored
    ACKD_n = 1'b0;
    tick();
    chk("idle_ack_done", {31'b0, done}, 32'd0);
    chk("idle_ack_busy", {31'b0, busy}, 32'd0);
    ACKD_n = 1'b1;

    // lw, single-cycle acknowledge
    request(1'b0, 3'b010, 32'h08000000, '0);
    tick();
    chk("lw_mreq", {31'b0, MREQ}, 32'd1);
    chk("lw_busy", {31'b0, busy}, 32'd1);
    chk("lw_size", {30'b0, SIZE}, 32'd0);
    chk("lw_dad", DAD, 32'h08000000);
    chk("lw_write", {31'b0, WRITE}, 32'd0);
    chk("lw_done_early", {31'b0, done}, 32'd0);
    req = 1'b0;
    bus_drv = 32'h80FF1234; bus_en = 1'b1; ACKD_n = 1'b0;
    tick();
    chk("lw_done", {31'b0, done}, 32'd1);
    chk("lw_mreq_off", {31'b0, MREQ}, 32'd0);
    chk("lw_busy_off", {31'b0, busy}, 32'd0);
    chk("lw_rdata", rdata, 32'h80FF1234);
    bus_en = 1'b0; ACKD_n = 1'b1;
    tick();
    chk("lw_done_pulse", {31'b0, done}, 32'd0);
    chk("lw_rdata_hold", rdata, 32'h80FF1234);

    // lb then back-to-back lbu accepted in the done cycle
    request(1'b0, 3'b000, 32'h08000003, '0);
    tick();
    chk("lb_size", {30'b0, SIZE}, 32'd2);
    req = 1'b0;
    bus_drv = 32'h00000080; bus_en = 1'b1; ACKD_n = 1'b0;
    tick();
    chk("lb_done", {31'b0, done}, 32'd1);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    chk("b2b_gap_mreq", {31'b0, MREQ}, 32'd0);
    ACKD_n = 1'b1;
    request(1'b0, 3'b100, 32'h08000003, '0);
    tick();
    chk("lbu_b2b_mreq", {31'b0, MREQ}, 32'd1);
    req = 1'b0; ACKD_n = 1'b0;
    tick();
    chk("lbu_rdata", rdata, 32'h00000080);
    bus_en = 1'b0; ACKD_n = 1'b1;

    // lh sign extension
    request(1'b0, 3'b001, 32'h08000002, '0);
    tick();
    req = 1'b0;
    bus_drv = 32'h1234F00D; bus_en = 1'b1; ACKD_n = 1'b0;
    tick();
    chk("lh_rdata", rdata, 32'hFFFFF00D);
    bus_en = 1'b0; ACKD_n = 1'b1;

    // sh with one wait cycle; req while busy ignored
    request(1'b1, 3'b001, 32'h08000002, 32'hDEADBEEF);
    tick();
    chk("sh_write", {31'b0, WRITE}, 32'd1);
    chk("sh_size", {30'b0, SIZE}, 32'd1);
    chk("sh_ddt", DDT, 32'h0000BEEF);
    funct3 = 3'b011; addr = 32'h0000_0010;
    tick();
    chk("sh_busy_req_err", {31'b0, err_req}, 32'd0);
    chk("sh_hold_ddt", DDT, 32'h0000BEEF);
    chk("sh_hold_dad", DAD, 32'h08000002);
    chk("sh_hold_size", {30'b0, SIZE}, 32'd1);
    req = 1'b0; ACKD_n = 1'b0;
    tick();
    chk("sh_done", {31'b0, done}, 32'd1);
    chk("sh_write_off", {31'b0, WRITE}, 32'd0);
    chk("sh_rdata_keep", rdata, 32'hFFFFF00D);
    ACKD_n = 1'b1;
    probe_released("sh_ddt_z");

    // Misaligned lw and illegal funct3
    request(1'b0, 3'b010, 32'h08000001, '0);
    tick();
    chk("mis_err", {31'b0, err_req}, 32'd1);
    chk("mis_mreq", {31'b0, MREQ}, 32'd0);
    chk("mis_busy", {31'b0, busy}, 32'd0);
    req = 1'b0;
    tick();
    chk("mis_err_pulse", {31'b0, err_req}, 32'd0);
    chk("mis_mreq2", {31'b0, MREQ}, 32'd0);
    request(1'b0, 3'b011, 32'h08000000, '0);
    tick();
    chk("ill_err", {31'b0, err_req}, 32'd1);
    chk("ill_mreq", {31'b0, MREQ}, 32'd0);
    request(1'b1, 3'b100, 32'h08000000, '0);
    tick();
    chk("ill_store_err", {31'b0, err_req}, 32'd1);
    req = 1'b0;
    tick();
    chk("ill_mreq2", {31'b0, MREQ}, 32'd0);

    // Timeout: MREQ high for 4 cycles then abort
    request(1'b0, 3'b010, 32'h08000100, '0);
    tick();
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("tmo_mreq_on", {31'b0, MREQ}, 32'd1);
      chk("tmo_err_early", {31'b0, err_timeout}, 32'd0);
      tick();
    end
    chk("tmo_mreq_4th", {31'b0, MREQ}, 32'd1);
    tick();
    chk("tmo_err", {31'b0, err_timeout}, 32'd1);
    chk("tmo_mreq_off", {31'b0, MREQ}, 32'd0);
    chk("tmo_busy_off", {31'b0, busy}, 32'd0);
    chk("tmo_done", {31'b0, done}, 32'd0);
    chk("tmo_rdata", rdata, 32'hFFFFF00D);
    tick();
    chk("tmo_err_pulse", {31'b0, err_timeout}, 32'd0);

    // Ack on the 4th cycle wins over timeout
    request(1'b0, 3'b010, 32'h08000104, '0);
    tick();
    req = 1'b0;
    tick(); tick(); tick();
    chk("tack_mreq", {31'b0, MREQ}, 32'd1);
    bus_drv = 32'h11223344; bus_en = 1'b1; ACKD_n = 1'b0;
    tick();
    chk("tack_done", {31'b0, done}, 32'd1);
    chk("tack_err", {31'b0, err_timeout}, 32'd0);
    chk("tack_rdata", rdata, 32'h11223344);
    bus_en = 1'b0; ACKD_n = 1'b1;

    // Reset mid-BUS during a store
    request(1'b1, 3'b010, 32'h08000200, 32'hCAFEF00D);
    tick();
    req = 1'b0;
    chk("rstmid_mreq_on", {31'b0, MREQ}, 32'd1);
    chk("rstmid_ddt", DDT, 32'hCAFEF00D);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_mreq_off", {31'b0, MREQ}, 32'd0);
    chk("rstmid_busy_off", {31'b0, busy}, 32'd0);
    chk("rstmid_done", {31'b0, done}, 32'd0);
    probe_released("rstmid_ddt_z");
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid_done2", {31'b0, done}, 32'd0);
    chk("rstmid_rdata", rdata, 32'd0);

    // First request after reset
    request(1'b0, 3'b101, 32'h08000002, '0);
    tick();
    chk("post_mreq", {31'b0, MREQ}, 32'd1);
    chk("post_size", {30'b0, SIZE}, 32'd1);
    req = 1'b0;
    bus_drv = 32'h0000_9ABC; bus_en = 1'b1; ACKD_n = 1'b0;
    tick();
    chk("post_done", {31'b0, done}, 32'd1);
    chk("post_rdata", rdata, 32'h00009ABC);
    bus_en = 1'b0; ACKD_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
